// File: rtl/alu_seq_ctrl.sv
// Sequential 4-bit ALU with valid/ready handshakes and a 4-step restoring divider.
// One command in flight at a time: IDLE accepts, EXEC/DIV compute, DONE holds until consumed.
module alu_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] opcode,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero,
  output logic       err
);

  localparam int unsigned OPW  = 4;
  localparam int unsigned DW   = 4;
  localparam int unsigned RESW = 8;
  localparam int unsigned CNTW = 3;

  localparam logic [OPW-1:0] OP_AND  = 4'd0;
  localparam logic [OPW-1:0] OP_OR   = 4'd1;
  localparam logic [OPW-1:0] OP_XOR  = 4'd2;
  localparam logic [OPW-1:0] OP_XNOR = 4'd3;
  localparam logic [OPW-1:0] OP_NAND = 4'd4;
  localparam logic [OPW-1:0] OP_NOR  = 4'd5;
  localparam logic [OPW-1:0] OP_NOT  = 4'd6;
  localparam logic [OPW-1:0] OP_ADD  = 4'd7;
  localparam logic [OPW-1:0] OP_SUB  = 4'd8;
  localparam logic [OPW-1:0] OP_MUL  = 4'd9;
  localparam logic [OPW-1:0] OP_SHL  = 4'd10;
  localparam logic [OPW-1:0] OP_SHR  = 4'd11;
  localparam logic [OPW-1:0] OP_DIV  = 4'd12;

  // Divider runs 4 iterations then spends one more DIV cycle publishing the result.
  localparam logic [CNTW-1:0] DIV_LAST = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DIV,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [OPW-1:0]  r_op,        w_op_nxt;
  logic [DW-1:0]   r_a,         w_a_nxt;
  logic [DW-1:0]   r_b,         w_b_nxt;
  logic [DW-1:0]   r_rem,       w_rem_nxt;
  logic [DW-1:0]   r_quo,       w_quo_nxt;
  logic [CNTW-1:0] r_cnt,       w_cnt_nxt;
  logic            r_in_ready,  w_in_ready_nxt;
  logic            r_out_valid, w_out_valid_nxt;
  logic [RESW-1:0] r_result,    w_result_nxt;
  logic            r_carry,     w_carry_nxt;
  logic            r_zero,      w_zero_nxt;
  logic            r_err,       w_err_nxt;

  logic [RESW-1:0] w_alu_res;
  logic            w_alu_carry;
  logic            w_alu_err;
  logic [DW:0]     w_sum;

  logic [DW:0]     w_div_shift;
  logic            w_div_ge;
  logic [DW-1:0]   w_div_diff;
  logic [RESW-1:0] w_div_res;

  assign w_sum = (DW+1)'(r_a) + (DW+1)'(r_b);

  // Single-cycle operations, evaluated from the captured command.
  always_comb begin
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    w_alu_err   = 1'b0;
    case (r_op)
      OP_AND:  w_alu_res = {4'h0, r_a & r_b};
      OP_OR:   w_alu_res = {4'h0, r_a | r_b};
      OP_XOR:  w_alu_res = {4'h0, r_a ^ r_b};
      OP_XNOR: w_alu_res = {4'h0, ~(r_a ^ r_b)};
      OP_NAND: w_alu_res = {4'h0, ~(r_a & r_b)};
      OP_NOR:  w_alu_res = {4'h0, ~(r_a | r_b)};
      OP_NOT:  w_alu_res = {4'h0, ~r_a};
      OP_ADD: begin
        w_alu_res   = {4'h0, w_sum[DW-1:0]};
        w_alu_carry = w_sum[DW];
      end
      OP_SUB: begin
        w_alu_res   = {4'h0, DW'(r_a - r_b)};
        w_alu_carry = (r_a < r_b);
      end
      OP_MUL:  w_alu_res = RESW'(r_a) * RESW'(r_b);
      OP_SHL:  w_alu_res = {4'h0, DW'(r_a << r_b[1:0])};
      OP_SHR:  w_alu_res = {4'h0, DW'(r_a >> r_b[1:0])};
      OP_DIV: begin
        // Only a zero divisor reaches EXEC with a DIV opcode.
        w_alu_res = {r_a, 4'hF};
        w_alu_err = 1'b1;
      end
      default: w_alu_err = 1'b1;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  // When it fits the true difference is below the divisor, so 4-bit wrap-around is exact.
  assign w_div_shift = {r_rem, r_quo[DW-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  assign w_div_diff  = w_div_shift[DW-1:0] - r_b;
  assign w_div_res   = {r_rem, r_quo};

  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_a_nxt         = r_a;
    w_b_nxt         = r_b;
    w_rem_nxt       = r_rem;
    w_quo_nxt       = r_quo;
    w_cnt_nxt       = r_cnt;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_result_nxt    = r_result;
    w_carry_nxt     = r_carry;
    w_zero_nxt      = r_zero;
    w_err_nxt       = r_err;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_op_nxt       = opcode;
          w_a_nxt        = a;
          w_b_nxt        = b;
          w_rem_nxt      = '0;
          w_quo_nxt      = a;
          w_cnt_nxt      = '0;
          w_in_ready_nxt = 1'b0;
          if (opcode == OP_DIV && b != '0) w_state_nxt = S_DIV;
          else                             w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_result_nxt    = w_alu_res;
        w_carry_nxt     = w_alu_carry;
        w_err_nxt       = w_alu_err;
        w_zero_nxt      = (w_alu_res == '0);
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_DONE;
      end
      S_DIV: begin
        if (r_cnt == DIV_LAST) begin
          w_result_nxt    = w_div_res;
          w_carry_nxt     = 1'b0;
          w_err_nxt       = 1'b0;
          w_zero_nxt      = (w_div_res == '0);
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end else begin
          w_rem_nxt = w_div_ge ? w_div_diff : w_div_shift[DW-1:0];
          w_quo_nxt = {r_quo[DW-2:0], w_div_ge};
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_op        <= w_op_nxt;
      r_a         <= w_a_nxt;
      r_b         <= w_b_nxt;
      r_rem       <= w_rem_nxt;
      r_quo       <= w_quo_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_result    <= w_result_nxt;
      r_carry     <= w_carry_nxt;
      r_zero      <= w_zero_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed table-driven bench for alu_seq_ctrl plus hand-written hold and reset sequences.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] opcode;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       zero;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  typedef struct {
    logic [3:0] op;
    logic [3:0] va;
    logic [3:0] vb;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       e;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] va, input logic [3:0] vb);
    opcode   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts cycles from acceptance to out_valid; flags any cycle where in_ready was seen high.
  task automatic wait_out(output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = !in_ready;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
      if (in_ready) busy_ok = 1'b0;
    end
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int         lat;
    logic       busy_ok;
    logic       seen;
    string      nm;

    // op, a, b, result, carry, zero, err, latency
    vecs.push_back('{4'd0,  4'b1100, 4'b1010, 8'h08, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd0,  4'b0101, 4'b1010, 8'h00, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd1,  4'b1100, 4'b1010, 8'h0E, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd2,  4'b1100, 4'b1010, 8'h06, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd3,  4'b1100, 4'b1010, 8'h09, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd4,  4'b1100, 4'b1010, 8'h07, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd5,  4'b1100, 4'b1010, 8'h01, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd6,  4'b1100, 4'b1010, 8'h03, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd7,  4'b1101, 4'b1010, 8'h07, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd7,  4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{4'd8,  4'b1101, 4'b1010, 8'h03, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd8,  4'b0011, 4'b0101, 8'h0E, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd9,  4'b1101, 4'b1010, 8'h82, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd9,  4'b1111, 4'b1111, 8'hE1, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd10, 4'b1011, 4'b0110, 8'h0C, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd11, 4'b1010, 4'b0111, 8'h01, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{4'd12, 4'b1010, 4'b0011, 8'h13, 1'b0, 1'b0, 1'b0, 5});
    vecs.push_back('{4'd12, 4'b1111, 4'b0001, 8'h0F, 1'b0, 1'b0, 1'b0, 5});
    vecs.push_back('{4'd12, 4'b0011, 4'b0111, 8'h30, 1'b0, 1'b0, 1'b0, 5});
    vecs.push_back('{4'd12, 4'b0110, 4'b0000, 8'h6F, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{4'd14, 4'b0110, 4'b0011, 8'h00, 1'b0, 1'b1, 1'b1, 1});
    vecs.push_back('{4'd13, 4'b1111, 4'b1111, 8'h00, 1'b0, 1'b1, 1'b1, 1});

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = '0;
    a         = '0;
    b         = '0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_carry",     32'(carry),     32'd0);
    check("rst_zero",      32'(zero),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      nm = $sformatf("v%0d_op%0d", i, vecs[i].op);
      check({nm, "_idle_ready"}, 32'(in_ready), 32'd1);
      issue(vecs[i].op, vecs[i].va, vecs[i].vb);
      wait_out(lat, busy_ok);
      check({nm, "_latency"}, 32'(lat),      32'(vecs[i].lat));
      check({nm, "_result"},  32'(result),   32'(vecs[i].res));
      check({nm, "_carry"},   32'(carry),    32'(vecs[i].c));
      check({nm, "_zero"},    32'(zero),     32'(vecs[i].z));
      check({nm, "_err"},     32'(err),      32'(vecs[i].e));
      check({nm, "_busy"},    32'(busy_ok),  32'd1);
      release_out(nm);
    end

    // Result held in DONE while the consumer stalls for 3 cycles.
    issue(4'd10, 4'b1010, 4'b0001);
    wait_out(lat, busy_ok);
    check("shl_hold_latency", 32'(lat), 32'd1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      check($sformatf("shl_hold%0d_valid", k),  32'(out_valid), 32'd1);
      check($sformatf("shl_hold%0d_result", k), 32'(result),    32'h04);
      check($sformatf("shl_hold%0d_ready", k),  32'(in_ready),  32'd0);
    end
    release_out("shl_hold");

    // Reset in the second DIV cycle aborts the command with no output.
    issue(4'd12, 4'b1010, 4'b0011);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("div_abort_valid",  32'(out_valid), 32'd0);
    check("div_abort_result", 32'(result),    32'h00);
    check("div_abort_ready",  32'(in_ready),  32'd1);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("div_abort_no_output", 32'(seen), 32'd0);

    // Reset wins over a simultaneous command.
    opcode   = 4'd7;
    a        = 4'd1;
    b        = 4'd1;
    in_valid = 1'b1;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    check("rst_prio_ready", 32'(in_ready),  32'd1);
    check("rst_prio_valid", 32'(out_valid), 32'd0);

    // Reset wins over out_ready in DONE; the held result is cleared.
    issue(4'd9, 4'b1101, 4'b1010);
    wait_out(lat, busy_ok);
    check("rst_done_pre_result", 32'(result), 32'h82);
    out_ready = 1'b1;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    check("rst_done_valid",  32'(out_valid), 32'd0);
    check("rst_done_result", 32'(result),    32'h00);
    check("rst_done_ready",  32'(in_ready),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have no parameters; datapath widths are fixed: 4-bit operands, 8-bit result.
REQ-002 SHALL provide the following ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  command present
- in_ready  output  1  block can accept a command
- opcode  input  4  operation select (REQ-006)
- a  input  4  operand A / dividend
- b  input  4  operand B / divisor / shift amount in b[1:0]
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- result  output  8  operation result
- carry  output  1  add carry-out / sub borrow
- zero  output  1  result == 8'h00
- err  output  1  divide-by-zero or illegal opcode

Function
REQ-003 SHALL implement FSM states IDLE, EXEC, DIV, DONE.
REQ-004 SHALL drive in_ready=1 only in IDLE; a command is accepted on an edge where in_valid && in_ready; opcode, a and b are captured into internal registers at that edge.
REQ-005 SHALL transition on acceptance: IDLE->EXEC for non-DIV opcodes and for DIV with b==0; IDLE->DIV for DIV with b!=0.
REQ-006 SHALL decode opcodes; Y = 4-bit value zero-extended to result[7:0]:
- 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 NOT a (b ignored)
- 7 ADD: Y=a+b; carry=carry-out; carry-in is 0
- 8 SUB: Y=a-b mod 16; carry=1 iff a<b
- 9 MUL: result = full 8-bit product a*b
- 10 SHL: logical shift of a left by b[1:0], zero fill
- 11 SHR: logical shift of a right by b[1:0], zero fill
- 12 DIV: result = {remainder[3:0], quotient[3:0]}
- 13-15 illegal: result=0, err=1
REQ-007 SHALL compute the result in EXEC in one cycle, register it, and move EXEC->DONE; out_valid=1 on the edge after acceptance (latency 1).
REQ-008 SHALL implement DIV as restoring division, one quotient bit per cycle, MSB first, for 4 cycles; DIV->DONE after the 4th iteration; out_valid=1 on the 5th edge after acceptance (latency 5).
REQ-009 SHALL return, for DIV with b==0 (via EXEC): result={a,4'hF}, err=1, latency 1.
REQ-010 SHALL drive carry=0 for all opcodes except ADD and SUB, and err=0 except as specified in REQ-006 and REQ-009.
REQ-011 SHALL compute zero from the final 8-bit result, including error cases.
REQ-012 SHALL hold result, carry, zero, err and out_valid stable in DONE until out_ready=1.
REQ-013 SHALL, on the DONE edge with out_ready=1, deassert out_valid and move DONE->IDLE; in_ready rises on that same edge. There is no bypass, so the minimum issue interval is 3 cycles.
REQ-014 SHALL ignore in_valid in every state except IDLE, and SHALL ignore out_ready in every state except DONE.

Reset
REQ-015 SHALL, when rst=1 at a rising edge, force state=IDLE, out_valid=0, result=8'h00, carry=0, zero=0, err=0, and clear the divider registers.
REQ-016 SHALL, on reset during EXEC, DIV or DONE, abort the operation with no result produced; in_ready=1 on the following cycle if rst=0.
REQ-017 SHALL give rst priority over in_valid and out_ready asserted on the same edge.

Verification
REQ-018 SHALL cover ADD a=4'b1101, b=4'b1010 -> result=8'h07, carry=1, zero=0, out_valid at 1 cycle after acceptance.
REQ-019 SHALL cover SUB a=4'b1101, b=4'b1010 -> result=8'h03, carry=0; and MUL of the same operands -> result=8'h82.
REQ-020 SHALL cover DIV a=4'b1010, b=4'b0011 -> result=8'h13 (rem 1, quot 3), out_valid exactly 5 cycles after acceptance, in_ready=0 throughout.
REQ-021 SHALL cover DIV a=4'b0110, b=0 -> result=8'h6F, err=1, latency 1; and opcode 14 -> result=8'h00, err=1, zero=1.
REQ-022 SHALL cover SHL a=4'b1010, b=2'b01 with out_ready held low for 3 cycles -> result=8'h04 held stable and out_valid=1 for all 3 cycles; exits DONE only on the out_ready edge.
REQ-023 SHALL cover rst=1 asserted in the 2nd DIV cycle -> next cycle out_valid=0, result=8'h00, in_ready=1, and no result is ever emitted for the aborted command.
